// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: opcodes, error codes, FSM states
// and the default settle time.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0010;
  localparam logic [3:0] OP_MOD  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_NOOP = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1011;

  // Opcodes above this value are reserved and rejected without touching the ALU
  localparam logic [3:0] OP_LAST_LEGAL = OP_XNOR;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_DIVZERO  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_controller_if.sv
// Bundle of command, result and ALU-facing signals of the ALU controller.
// The slave side is the controller; the master side is its environment.
interface alu_controller_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;

  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_out;
  logic [1:0]  alu_error;

  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [1:0]  res_error;

  logic [31:0] acc;
  logic [1:0]  sticky_err;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, alu_out, alu_error, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_opcode, res_valid, res_data, res_error,
           acc, sticky_err, busy
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, alu_out, alu_error, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_opcode, res_valid, res_data, res_error,
           acc, sticky_err, busy
  );

endinterface

// File: rtl/alu_controller.sv
// Sequences commands onto an external combinational ALU: holds its operands for
// SETTLE cycles, captures the result and hands it out over a valid/ready port.
module alu_controller
  import alu_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  alu_controller_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  settle_cnt;
  logic [3:0]  op_q;
  logic [31:0] in1_q;
  logic [31:0] in2_q;
  logic [63:0] res_data_q;
  logic [1:0]  res_error_q;
  logic [31:0] acc_q;
  logic [1:0]  sticky_q;

  logic        accept;
  logic        res_fire;
  logic        is_illegal;
  logic        cmd_ready_c;
  logic        res_valid_c;
  logic [3:0]  alu_opcode_c;
  logic [31:0] alu_in1_c;
  logic [31:0] alu_in2_c;

  assign accept     = bus.cmd_valid && (state == ST_IDLE);
  assign res_fire   = bus.res_ready && (state == ST_RESP);
  assign is_illegal = bus.cmd_op > OP_LAST_LEGAL;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    cmd_ready_c  = 1'b0;
    res_valid_c  = 1'b0;
    alu_opcode_c = OP_NOOP;
    alu_in1_c    = '0;
    alu_in2_c    = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (accept)
          next_state = (bus.cmd_load || is_illegal) ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode_c = op_q;
        alu_in1_c    = in1_q;
        alu_in2_c    = in2_q;
        if (settle_cnt == 4'd0) next_state = ST_RESP;
      end
      ST_RESP: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Loads and reserved opcodes resolve at accept; ALU ops capture on the last EXEC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      op_q        <= OP_NOOP;
      in1_q       <= '0;
      in2_q       <= '0;
      res_data_q  <= '0;
      res_error_q <= ERR_NONE;
      acc_q       <= '0;
      sticky_q    <= ERR_NONE;
    end else begin
      if (accept) begin
        if (bus.cmd_load) begin
          res_data_q  <= {32'b0, bus.cmd_data};
          res_error_q <= ERR_NONE;
          acc_q       <= bus.cmd_data;
          sticky_q    <= ERR_NONE;
        end else if (is_illegal) begin
          res_data_q  <= '0;
          res_error_q <= ERR_ILLEGAL;
        end else begin
          op_q       <= bus.cmd_op;
          in1_q      <= bus.cmd_data;
          in2_q      <= acc_q;
          settle_cnt <= SETTLE_LAST;
        end
      end
      if (state == ST_EXEC) begin
        if (settle_cnt == 4'd0) begin
          res_data_q  <= bus.alu_out;
          res_error_q <= bus.alu_error;
        end else begin
          settle_cnt <= settle_cnt - 4'd1;
        end
      end
      if (res_fire) begin
        if (res_error_q == ERR_NONE) acc_q <= res_data_q[31:0];
        sticky_q <= sticky_q | res_error_q;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.res_valid  = res_valid_c;
  assign bus.alu_opcode = alu_opcode_c;
  assign bus.alu_in1    = alu_in1_c;
  assign bus.alu_in2    = alu_in2_c;
  assign bus.res_data   = res_data_q;
  assign bus.res_error  = res_error_q;
  assign bus.acc        = acc_q;
  assign bus.sticky_err = sticky_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_controller.sv
// Directed testbench for alu_controller with a small behavioural ALU standing in
// for the breadboard ALU (SUB/DIV/MOD compute acc-relative: in2 op in1).
module tb_alu_controller;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_controller_if bus ();

  alu_controller #(.SETTLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; outside real opcodes it drives junk so stray sampling shows up
  always_comb begin
    bus.alu_out   = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.alu_error = ERR_NONE;
    case (bus.alu_opcode)
      OP_ADD: bus.alu_out = {32'b0, bus.alu_in2 + bus.alu_in1};
      OP_SUB: bus.alu_out = {32'b0, bus.alu_in2 - bus.alu_in1};
      OP_AND: bus.alu_out = {32'b0, bus.alu_in2 & bus.alu_in1};
      OP_OR:  bus.alu_out = {32'b0, bus.alu_in2 | bus.alu_in1};
      OP_XOR: bus.alu_out = {32'b0, bus.alu_in2 ^ bus.alu_in1};
      OP_DIV, OP_MOD: begin
        if (bus.alu_in1 == 32'd0) begin
          bus.alu_out   = 64'd0;
          bus.alu_error = ERR_DIVZERO;
        end else if (bus.alu_opcode == OP_DIV) begin
          bus.alu_out = {32'b0, bus.alu_in2 / bus.alu_in1};
        end else begin
          bus.alu_out = {32'b0, bus.alu_in2 % bus.alu_in1};
        end
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic load, input logic [3:0] op, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic take_resp();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    checks++;
    if (bus.acc !== 32'd0 || bus.sticky_err !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state got acc=%h sticky=%b busy=%b exp 0/00/0", bus.acc, bus.sticky_err, bus.busy);
    end
    checks++;
    if (bus.alu_opcode !== OP_NOOP || bus.alu_in1 !== 32'd0 || bus.alu_in2 !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_alu_drive got op=%b in1=%h in2=%h exp 1001/0/0", bus.alu_opcode, bus.alu_in1, bus.alu_in2);
    end
    checks++;
    if (bus.res_data !== 64'd0 || bus.res_error !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_result got data=%h err=%b exp 0/00", bus.res_data, bus.res_error);
    end
  endtask

  task automatic test_load_add();
    int n;
    send_cmd(1'b1, OP_NOOP, 32'd7);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd7 || bus.acc !== 32'd7) begin
      errors++; $display("[TB] FAIL load7 got valid=%b data=%h acc=%h exp 1/7/7", bus.res_valid, bus.res_data, bus.acc);
    end
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL load7_ready_in_resp got %b exp 0", bus.cmd_ready); end
    take_resp();
    send_cmd(1'b0, OP_ADD, 32'd5);
    checks++;
    if (bus.alu_opcode !== OP_ADD || bus.alu_in1 !== 32'd5 || bus.alu_in2 !== 32'd7 || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_exec1 got op=%b in1=%h in2=%h valid=%b exp 0000/5/7/0", bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.res_valid);
    end
    tick();
    checks++;
    if (bus.alu_opcode !== OP_ADD || bus.alu_in1 !== 32'd5 || bus.alu_in2 !== 32'd7 || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_exec2 got op=%b in1=%h in2=%h valid=%b exp 0000/5/7/0", bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.res_valid);
    end
    wait_resp(n);
    checks++;
    if (n !== 1) begin errors++; $display("[TB] FAIL add_latency got %0d cycles after accept exp 3", n + 2); end
    checks++;
    if (bus.res_data !== 64'd12 || bus.res_error !== ERR_NONE) begin
      errors++; $display("[TB] FAIL add_result got data=%h err=%b exp c/00", bus.res_data, bus.res_error);
    end
    checks++;
    if (bus.alu_opcode !== OP_NOOP || bus.alu_in1 !== 32'd0) begin
      errors++; $display("[TB] FAIL add_alu_release got op=%b in1=%h exp 1001/0", bus.alu_opcode, bus.alu_in1);
    end
    take_resp();
    checks++;
    if (bus.acc !== 32'd12 || bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_acc got acc=%h ready=%b valid=%b exp c/1/0", bus.acc, bus.cmd_ready, bus.res_valid);
    end
  endtask

  task automatic test_sub();
    int n;
    send_cmd(1'b0, OP_SUB, 32'd4);
    wait_resp(n);
    checks++;
    if (n !== 2 || bus.res_data !== 64'd8) begin
      errors++; $display("[TB] FAIL sub_result got lat=%0d data=%h exp 2/8", n, bus.res_data);
    end
    take_resp();
    checks++;
    if (bus.acc !== 32'd8) begin errors++; $display("[TB] FAIL sub_acc got %h exp 8", bus.acc); end
  endtask

  task automatic test_div_zero();
    int n;
    send_cmd(1'b0, OP_DIV, 32'd0);
    wait_resp(n);
    checks++;
    if (n !== 2 || bus.res_error !== ERR_DIVZERO) begin
      errors++; $display("[TB] FAIL div0_error got lat=%0d err=%b exp 2/10", n, bus.res_error);
    end
    take_resp();
    checks++;
    if (bus.acc !== 32'd8 || bus.sticky_err !== 2'b10) begin
      errors++; $display("[TB] FAIL div0_acc got acc=%h sticky=%b exp 8/10", bus.acc, bus.sticky_err);
    end
    send_cmd(1'b1, OP_NOOP, 32'd1);
    checks++;
    if (bus.sticky_err !== 2'b00 || bus.acc !== 32'd1) begin
      errors++; $display("[TB] FAIL load_clears_sticky got sticky=%b acc=%h exp 00/1", bus.sticky_err, bus.acc);
    end
    take_resp();
  endtask

  task automatic test_and();
    int n;
    send_cmd(1'b1, OP_NOOP, 32'hDB);
    take_resp();
    send_cmd(1'b0, OP_AND, 32'h6D);
    wait_resp(n);
    checks++;
    if (n !== 2 || bus.res_data !== 64'h49) begin
      errors++; $display("[TB] FAIL and_result got lat=%0d data=%h exp 2/49", n, bus.res_data);
    end
    take_resp();
    checks++;
    if (bus.acc !== 32'h49) begin errors++; $display("[TB] FAIL and_acc got %h exp 49", bus.acc); end
  endtask

  task automatic test_illegal();
    send_cmd(1'b0, 4'b1100, 32'h1234);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.alu_opcode !== OP_NOOP) begin
      errors++; $display("[TB] FAIL illegal_no_exec got valid=%b op=%b exp 1/1001", bus.res_valid, bus.alu_opcode);
    end
    checks++;
    if (bus.res_data !== 64'd0 || bus.res_error !== ERR_ILLEGAL) begin
      errors++; $display("[TB] FAIL illegal_result got data=%h err=%b exp 0/11", bus.res_data, bus.res_error);
    end
    take_resp();
    checks++;
    if (bus.acc !== 32'h49 || bus.sticky_err !== 2'b11) begin
      errors++; $display("[TB] FAIL illegal_acc got acc=%h sticky=%b exp 49/11", bus.acc, bus.sticky_err);
    end
  endtask

  task automatic test_backpressure();
    int n;
    send_cmd(1'b1, OP_NOOP, 32'd3);
    take_resp();
    send_cmd(1'b0, OP_ADD, 32'd10);
    wait_resp(n);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_data  = 32'h55;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 64'd13 || bus.cmd_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold cycle %0d got valid=%b data=%h ready=%b exp 1/d/0", i, bus.res_valid, bus.res_data, bus.cmd_ready);
      end
      tick();
    end
    checks++;
    if (bus.acc !== 32'd3) begin errors++; $display("[TB] FAIL stall_acc_early got %h exp 3", bus.acc); end
    take_resp();
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    checks++;
    if (bus.acc !== 32'd13 || bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_release got acc=%h ready=%b valid=%b exp d/1/0", bus.acc, bus.cmd_ready, bus.res_valid);
    end
  endtask

  task automatic test_reset_in_flight();
    send_cmd(1'b1, OP_NOOP, 32'd9);
    take_resp();
    send_cmd(1'b0, OP_ADD, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.acc !== 32'd0 || bus.res_valid !== 1'b0 || bus.alu_opcode !== OP_NOOP) begin
      errors++; $display("[TB] FAIL rst_exec got ready=%b acc=%h valid=%b op=%b exp 1/0/0/1001", bus.cmd_ready, bus.acc, bus.res_valid, bus.alu_opcode);
    end
    send_cmd(1'b1, OP_NOOP, 32'd4);
    bus.res_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.acc !== 32'd0 || bus.res_valid !== 1'b0 || bus.res_data !== 64'd0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_over_handshake got acc=%h valid=%b data=%h busy=%b exp 0/0/0/0", bus.acc, bus.res_valid, bus.res_data, bus.busy);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = OP_NOOP;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_load_add();
    test_sub();
    test_div_zero();
    test_and();
    test_illegal();
    test_backpressure();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before bench completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
